// File: rtl/snes_pad_poller.sv
// Two-player SNES/NES serial pad poller: latches both pads, then shifts NUM_BITS bits
// out of each in lock-step and presents active-high pressed masks with a one-cycle Valid.
module snes_pad_poller #(
    parameter int unsigned LATCH_CYCLES = 300,
    parameter int unsigned HALF_CYCLES  = 150,
    parameter int unsigned NUM_BITS     = 16
) (
    input  logic        Clock,
    input  logic        NReset,
    input  logic        Start,
    input  logic        Enable1,
    input  logic        Enable2,
    input  logic        SNESData1,
    input  logic        SNESData2,
    output logic        NStrobe_Latch1,
    output logic        NShift_Clock1,
    output logic        NStrobe_Latch2,
    output logic        NShift_Clock2,
    output logic [15:0] Buttons1,
    output logic [15:0] Buttons2,
    output logic        Valid,
    output logic        Busy
);

    localparam int unsigned CntMax = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_CYCLES - 1);
    localparam logic [3:0]      BitLast   = 4'(NUM_BITS - 1);
    localparam logic [15:0]     BitMask   = 16'((32'd1 << NUM_BITS) - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSettle,
        StShiftLo,
        StShiftHi,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            en1_q, en1_d, en2_q, en2_d;
    logic [15:0]     shift1_q, shift1_d, shift2_q, shift2_d;
    logic [15:0]     buttons1_q, buttons1_d, buttons2_q, buttons2_d;
    logic            valid_q, valid_d;
    logic            latch1_q, latch1_d, latch2_q, latch2_d;
    logic            sclk1_q, sclk1_d, sclk2_q, sclk2_d;
    logic [1:0]      sync1_q, sync2_q;
    logic            phase_last;

    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            shift1_q   <= '0;
            shift2_q   <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            valid_q    <= 1'b0;
            latch1_q   <= 1'b1;
            latch2_q   <= 1'b1;
            sclk1_q    <= 1'b1;
            sclk2_q    <= 1'b1;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            en1_q      <= en1_d;
            en2_q      <= en2_d;
            shift1_q   <= shift1_d;
            shift2_q   <= shift2_d;
            buttons1_q <= buttons1_d;
            buttons2_q <= buttons2_d;
            valid_q    <= valid_d;
            latch1_q   <= latch1_d;
            latch2_q   <= latch2_d;
            sclk1_q    <= sclk1_d;
            sclk2_q    <= sclk2_d;
            sync1_q    <= {sync1_q[0], SNESData1};
            sync2_q    <= {sync2_q[0], SNESData2};
        end
    end

    assign phase_last = (state_q == StLatch) ? (cnt_q == LatchLast) : (cnt_q == HalfLast);

    always_comb begin
        state_d    = state_q;
        cnt_d      = phase_last ? '0 : cnt_q + CntW'(1);
        bit_d      = bit_q;
        en1_d      = en1_q;
        en2_d      = en2_q;
        shift1_d   = shift1_q;
        shift2_d   = shift2_q;
        buttons1_d = buttons1_q;
        buttons2_d = buttons2_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (Start) begin
                    en1_d    = Enable1;
                    en2_d    = Enable2;
                    bit_d    = '0;
                    shift1_d = '0;
                    shift2_d = '0;
                    state_d  = StLatch;
                end
            end
            StLatch: begin
                if (phase_last) state_d = StSettle;
            end
            StSettle: begin
                if (phase_last) state_d = StShiftLo;
            end
            StShiftLo: begin
                if (phase_last) begin
                    shift1_d[bit_q] = sync1_q[1];
                    shift2_d[bit_q] = sync2_q[1];
                    state_d         = StShiftHi;
                end
            end
            StShiftHi: begin
                if (phase_last) begin
                    if (bit_q == BitLast) begin
                        // Load results on entry to DONE so Buttons and Valid appear together.
                        buttons1_d = en1_q ? (~shift1_q & BitMask) : '0;
                        buttons2_d = en2_q ? (~shift2_q & BitMask) : '0;
                        valid_d    = 1'b1;
                        state_d    = StDone;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = StShiftLo;
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        // Pad pins are registered copies of the next state, so they align with state_q.
        latch1_d = !((state_d == StLatch) && en1_d);
        latch2_d = !((state_d == StLatch) && en2_d);
        sclk1_d  = !((state_d == StShiftLo) && en1_d);
        sclk2_d  = !((state_d == StShiftLo) && en2_d);
    end

    assign NStrobe_Latch1 = latch1_q;
    assign NStrobe_Latch2 = latch2_q;
    assign NShift_Clock1  = sclk1_q;
    assign NShift_Clock2  = sclk2_q;
    assign Buttons1       = buttons1_q;
    assign Buttons2       = buttons2_q;
    assign Valid          = valid_q;
    assign Busy           = (state_q != StIdle);

endmodule

// File: tb/tb_snes_pad_poller.sv
// Randomised self-checking bench for snes_pad_poller: a cycle-offset model of a poll,
// behavioural pads, and directed checks of latency, masking, abort and restart.
module tb_snes_pad_poller;

    localparam int unsigned L = 4;
    localparam int unsigned H = 4;
    localparam int unsigned N = 16;
    localparam int P  = L + H + 2 * H * N + 1;
    localparam int P8 = L + H + 2 * H * 8 + 1;

    logic        Clock, NReset, Start, Enable1, Enable2, SNESData1, SNESData2;
    logic        NStrobe_Latch1, NShift_Clock1, NStrobe_Latch2, NShift_Clock2;
    logic [15:0] Buttons1, Buttons2;
    logic        Valid, Busy;

    logic        start8, en8, d81, d82, l81, c81, l82, c82, valid8, busy8;
    logic [15:0] b81, b82;

    logic [15:0] pad1, pad2, sr1, sr2, sr81, sr82;
    logic        pad2_zero;

    int checks = 0;
    int errors = 0;
    int vcnt, l1lo, l2lo, c1f, c2f, c81f;

    snes_pad_poller #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .NUM_BITS(N)) dut (
        .Clock(Clock), .NReset(NReset), .Start(Start), .Enable1(Enable1), .Enable2(Enable2),
        .SNESData1(SNESData1), .SNESData2(SNESData2),
        .NStrobe_Latch1(NStrobe_Latch1), .NShift_Clock1(NShift_Clock1),
        .NStrobe_Latch2(NStrobe_Latch2), .NShift_Clock2(NShift_Clock2),
        .Buttons1(Buttons1), .Buttons2(Buttons2), .Valid(Valid), .Busy(Busy)
    );

    snes_pad_poller #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .NUM_BITS(8)) dut8 (
        .Clock(Clock), .NReset(NReset), .Start(start8), .Enable1(en8), .Enable2(en8),
        .SNESData1(d81), .SNESData2(d82),
        .NStrobe_Latch1(l81), .NShift_Clock1(c81),
        .NStrobe_Latch2(l82), .NShift_Clock2(c82),
        .Buttons1(b81), .Buttons2(b82), .Valid(valid8), .Busy(busy8)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural pads: latch loads the inverted pressed mask, each rising shift clock
    // moves the next bit out and fills with 1s (released).
    initial begin
        sr1 = '1;
        forever begin
            @(negedge NStrobe_Latch1 or posedge NShift_Clock1);
            if (!NStrobe_Latch1) sr1 = ~pad1;
            else                 sr1 = {1'b1, sr1[15:1]};
        end
    end
    initial begin
        sr2 = '1;
        forever begin
            @(negedge NStrobe_Latch2 or posedge NShift_Clock2);
            if (!NStrobe_Latch2) sr2 = ~pad2;
            else                 sr2 = {1'b1, sr2[15:1]};
        end
    end
    initial begin
        sr81 = '1;
        forever begin
            @(negedge l81 or posedge c81);
            if (!l81) sr81 = ~16'h00A5;
            else      sr81 = {1'b1, sr81[15:1]};
        end
    end
    initial begin
        sr82 = '1;
        forever begin
            @(negedge l82 or posedge c82);
            if (!l82) sr82 = ~16'hFF3C;
            else      sr82 = {1'b1, sr82[15:1]};
        end
    end

    assign SNESData1 = sr1[0];
    assign SNESData2 = pad2_zero ? 1'b0 : sr2[0];
    assign d81       = sr81[0];
    assign d82       = sr82[0];

    initial forever begin
        @(negedge Clock);
        vcnt += int'(Valid);
        l1lo += int'(!NStrobe_Latch1);
        l2lo += int'(!NStrobe_Latch2);
    end
    initial forever begin @(negedge NShift_Clock1); c1f++; end
    initial forever begin @(negedge NShift_Clock2); c2f++; end
    initial forever begin @(negedge c81); c81f++; end

    // Reference model: a poll is a window of P cycles after the accepting edge; every pin
    // value follows from the cycle offset within that window.
    bit          m_act = 1'b0;
    bit          m_en1, m_en2;
    int          m_o;
    logic [15:0] m_b1 = '0;
    logic [15:0] m_b2 = '0;

    initial forever begin
        logic e_l1, e_c1, e_l2, e_c2, e_v, lat_win, clk_lo;
        @(negedge Clock);
        if (!NReset) begin
            m_act = 1'b0;
            m_b1  = '0;
            m_b2  = '0;
        end else if (m_act && m_o == P) begin
            m_b1 = m_en1 ? pad1 : '0;
            m_b2 = m_en2 ? pad2 : '0;
        end
        lat_win = m_act && m_o >= 1 && m_o <= int'(L);
        clk_lo  = m_act && m_o >= int'(L + H + 1) && m_o <= int'(L + H + 2 * H * N)
                  && (((m_o - int'(L + H + 1)) / int'(H)) % 2 == 0);
        e_l1 = !(lat_win && m_en1);
        e_l2 = !(lat_win && m_en2);
        e_c1 = !(clk_lo && m_en1);
        e_c2 = !(clk_lo && m_en2);
        e_v  = m_act && m_o == P;
        check("pins",
              32'({NStrobe_Latch1, NShift_Clock1, NStrobe_Latch2, NShift_Clock2, Valid, Busy}),
              32'({e_l1, e_c1, e_l2, e_c2, e_v, m_act}));
        check("buttons1", 32'(Buttons1), 32'(m_b1));
        check("buttons2", 32'(Buttons2), 32'(m_b2));
        if (NReset) begin
            if (m_act) begin
                if (m_o == P) m_act = 1'b0;
                else          m_o++;
            end else if (Start) begin
                m_act = 1'b1;
                m_o   = 1;
                m_en1 = Enable1;
                m_en2 = Enable2;
            end
        end
    end

    // Starts a poll from idle; offsets count cycles after the accepting edge.
    task automatic do_poll(input int xs1, input int xs2, input int abort_at,
                           output int lat, output bit busy_after);
        int n;
        lat        = -1;
        busy_after = 1'b1;
        Start      = 1'b1;
        @(posedge Clock); #2;
        Start = 1'b0;
        n     = 1;
        while (n < 1000) begin
            Start = (n == xs1) || (n == xs2);
            if (n == abort_at) begin
                NReset = 1'b0;
                #1;
                check("async_reset_pins",
                      32'({NStrobe_Latch1, NShift_Clock1, NStrobe_Latch2, NShift_Clock2,
                           Valid, Busy}), 32'(6'b111100));
                check("async_reset_b1", 32'(Buttons1), 32'h0);
                check("async_reset_b2", 32'(Buttons2), 32'h0);
                Start = 1'b0;
                return;
            end
            if (Valid) begin
                lat = n;
                break;
            end
            @(posedge Clock); #2;
            n++;
        end
        Start = 1'b0;
        @(posedge Clock); #2;
        busy_after = Busy;
    endtask

    task automatic clear_counts();
        vcnt = 0; l1lo = 0; l2lo = 0; c1f = 0; c2f = 0; c81f = 0;
    endtask

    initial begin
        int lat, n8;
        bit ba;
        NReset = 1'b0; Start = 1'b0; Enable1 = 1'b0; Enable2 = 1'b0;
        start8 = 1'b0; en8 = 1'b1; pad1 = '0; pad2 = '0; pad2_zero = 1'b0;
        clear_counts();
        repeat (3) @(posedge Clock);
        #2 NReset = 1'b1;

        // Idle after reset
        repeat (20) @(posedge Clock);
        #2;
        check("idle_pins", 32'({NStrobe_Latch1, NShift_Clock1, NStrobe_Latch2, NShift_Clock2,
                                Valid, Busy}), 32'(6'b111100));
        check("idle_b1", 32'(Buttons1), 32'h0);
        check("idle_b2", 32'(Buttons2), 32'h0);

        // Both players enabled
        pad1 = 16'h0005; pad2 = 16'h8000; Enable1 = 1'b1; Enable2 = 1'b1;
        clear_counts();
        do_poll(0, 0, 0, lat, ba);
        check("t2_latency", lat, 137);
        check("t2_b1", 32'(Buttons1), 32'h0005);
        check("t2_b2", 32'(Buttons2), 32'h8000);
        check("t2_latch1_low", l1lo, 4);
        check("t2_latch2_low", l2lo, 4);
        check("t2_clk1_pulses", c1f, 16);
        check("t2_clk2_pulses", c2f, 16);
        check("t2_valid_count", vcnt, 1);

        // Player 2 disabled, its data line held low
        pad1 = 16'h1234; Enable2 = 1'b0; pad2_zero = 1'b1;
        clear_counts();
        do_poll(0, 0, 0, lat, ba);
        check("t3_b1", 32'(Buttons1), 32'h1234);
        check("t3_b2", 32'(Buttons2), 32'h0);
        check("t3_latch2_low", l2lo, 0);
        check("t3_clk2_pulses", c2f, 0);
        pad2_zero = 1'b0; Enable2 = 1'b1;

        // Start re-pulsed mid-poll and on the last shift cycle
        pad1 = 16'hA5A5; pad2 = 16'h0F0F;
        clear_counts();
        do_poll(10, 136, 0, lat, ba);
        check("t4_latency", lat, 137);
        check("t4_valid_count", vcnt, 1);
        check("t4_busy_drops", 32'(ba), 32'h0);

        // Reset during bit 7 discards the poll
        clear_counts();
        do_poll(0, 0, int'(L + H + 1 + 2 * H * 7) + 1, lat, ba);
        repeat (3) @(posedge Clock);
        #2 NReset = 1'b1;
        repeat (150) @(posedge Clock);
        #2;
        check("t5_no_valid", vcnt, 0);
        check("t5_b1_cleared", 32'(Buttons1), 32'h0);
        pad1 = 16'h0F00; pad2 = 16'h00F1;
        do_poll(0, 0, 0, lat, ba);
        check("t5_restart_latency", lat, 137);
        check("t5_restart_b1", 32'(Buttons1), 32'h0F00);

        // NUM_BITS = 8 instance: only 8 pulses, upper bits masked
        clear_counts();
        start8 = 1'b1;
        @(posedge Clock); #2;
        start8 = 1'b0;
        n8 = 1;
        while (!valid8 && n8 < 500) begin
            @(posedge Clock); #2;
            n8++;
        end
        check("t6_latency", n8, P8);
        check("t6_b1", 32'(b81), 32'h00A5);
        check("t6_b2", 32'(b82), 32'h003C);
        check("t6_clk_pulses", c81f, 8);

        // Randomised polls: enables, pad contents, stray Starts, idle gaps
        for (int i = 0; i < 10; i++) begin
            pad1    = 16'($urandom);
            pad2    = 16'($urandom);
            Enable1 = 1'($urandom);
            Enable2 = 1'($urandom);
            do_poll(int'($urandom_range(1, P)), ($urandom_range(0, 1) == 1) ? P : 0, 0, lat, ba);
            check("rand_latency", lat, P);
            check("rand_b1", 32'(Buttons1), Enable1 ? 32'(pad1) : 32'h0);
            Enable1 = 1'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge Clock);
            #2;
        end

        repeat (2) @(posedge Clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
